// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared widths, state type and bit helper for the 16-to-4 sequential encoder
package encoder_pkg;

  localparam int CODE_W = 4;
  localparam int N      = 1 << CODE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Clears the lowest set bit; zero result on a nonzero input means it was one-hot.
  function automatic logic [N-1:0] clear_lowest(input logic [N-1:0] v);
    return v & (v - {{(N-1){1'b0}}, 1'b1});
  endfunction

endpackage

// File: rtl/encoder_16x4_seq_if.sv
// rtl/encoder_16x4_seq_if.sv - request load and code handshake bundle of the sequential encoder
interface encoder_16x4_seq_if;
  import encoder_pkg::*;

  logic              load;
  logic [N-1:0]      d_in;
  logic              busy;
  logic              valid;
  logic              ready;
  logic [CODE_W-1:0] code;
  logic              last;
  logic              done;

  modport master (
    output load, d_in, ready,
    input  busy, valid, code, last, done
  );

  modport slave (
    input  load, d_in, ready,
    output busy, valid, code, last, done
  );

endinterface

// File: rtl/prio_enc_16x4.sv
// rtl/prio_enc_16x4.sv - combinational lowest-set-bit encoder with any and one_hot flags
module prio_enc_16x4
  import encoder_pkg::*;
(
  input  logic [N-1:0]      vec,
  output logic [CODE_W-1:0] idx,
  output logic              any,
  output logic              one_hot
);

  // Scan from the top down so the lowest set bit is the final assignment.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = CODE_W'(i);
    end
  end

  assign any     = |vec;
  assign one_hot = any && (clear_lowest(vec) == '0);

endmodule

// File: rtl/encoder_16x4_seq.sv
// rtl/encoder_16x4_seq.sv - latches a request vector and emits each set index, lowest first, one per handshake
module encoder_16x4_seq
  import encoder_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  encoder_16x4_seq_if.slave  bus
);

  state_t            state;
  logic [N-1:0]      pending;
  logic [CODE_W-1:0] low_idx;
  logic              any_set;
  logic              single;

  prio_enc_16x4 u_prio (
    .vec     (pending),
    .idx     (low_idx),
    .any     (any_set),
    .one_hot (single)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load) begin
            pending <= bus.d_in;
            state   <= SCAN;
          end
        end
        SCAN: begin
          // A zero vector still passes through FIN so every accepted load ends with done.
          if (!any_set) begin
            state <= FIN;
          end else if (bus.ready) begin
            pending <= clear_lowest(pending);
            if (single) state <= FIN;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = (state != IDLE);
  assign bus.valid = (state == SCAN) && any_set;
  assign bus.code  = bus.valid ? low_idx : '0;
  assign bus.last  = bus.valid && single;
  assign bus.done  = (state == FIN);

endmodule

// File: tb/tb_encoder_16x4_seq.sv
// tb/tb_encoder_16x4_seq.sv - vector table, corner sequences and randomized round trip against a queue model
module tb_encoder_16x4_seq;
  import encoder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  encoder_16x4_seq_if bus ();

  encoder_16x4_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] vec;
    int          mode;
    bit          inject;
    int          exp_count;
    int          exp_first;
    int          exp_final;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},  bus.busy,  0);
    check({tag, "_valid"}, bus.valid, 0);
    check({tag, "_code"},  bus.code,  0);
    check({tag, "_last"},  bus.last,  0);
    check({tag, "_done"},  bus.done,  0);
  endtask

  // mode 0: ready high, 1: random ready, 2: ready alternating 1/0.
  // inject: attempt loads of 16'h0A00 during SCAN and FIN, which must be ignored.
  task automatic run_vec(input logic [15:0] vec, input int mode, input bit inject,
                         output int cnt, output int first, output int fin);
    int          q[$];
    int          k;
    int          cyc;
    int          prev;
    logic [15:0] recon;
    bit          got;
    bit          r;
    for (int i = 0; i < 16; i++) if (vec[i]) q.push_back(i);
    k = q.size();
    cnt = 0; first = -1; fin = -1; prev = -1; recon = '0; got = 0; cyc = 0;
    bus.d_in = vec;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    bus.d_in = 16'($urandom);
    while (!got && cyc < 200) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = (cyc % 2 == 0);
      endcase
      bus.ready = r;
      if (inject) begin
        bus.load = (cyc == 0);
        bus.d_in = 16'h0A00;
      end
      if (bus.done) begin
        got = 1;
        check("done_drained", q.size(), 0);
        check("fin_valid", bus.valid, 0);
        check("fin_busy", bus.busy, 1);
        if (mode == 0) check("done_latency", cyc + 1, ((k > 0) ? k : 1) + 1);
        if (inject) bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        check_quiet("after_fin");
      end else begin
        check("scan_busy", bus.busy, 1);
        if (q.size() > 0) begin
          check("valid", bus.valid, 1);
          check("code", bus.code, q[0]);
          check("last", bus.last, (q.size() == 1));
          if (r) begin
            check("ascending", (int'(bus.code) > prev), 1);
            prev = int'(bus.code);
            recon |= 16'(1) << bus.code;
            if (cnt == 0) first = int'(bus.code);
            fin = int'(bus.code);
            cnt++;
            void'(q.pop_front());
          end
        end else begin
          check("empty_valid", bus.valid, 0);
          check("empty_code", bus.code, 0);
          check("empty_last", bus.last, 0);
        end
        step();
        cyc++;
      end
    end
    if (!got) check("done_timeout", 0, 1);
    check("round_trip", recon, vec);
    check("handshakes", cnt, $countones(vec));
    bus.ready = 1'b0;
  endtask

  vec_t tbl[7];
  int   cnt, first, fin;

  initial begin
    bus.load  = 1'b0;
    bus.d_in  = '0;
    bus.ready = 1'b0;

    tbl[0] = '{16'h8001, 0, 1'b0,  2,  0, 15};
    tbl[1] = '{16'hFFFF, 2, 1'b0, 16,  0, 15};
    tbl[2] = '{16'h0000, 0, 1'b0,  0, -1, -1};
    tbl[3] = '{16'h0030, 0, 1'b1,  2,  4,  5};
    tbl[4] = '{16'h0001, 0, 1'b0,  1,  0,  0};
    tbl[5] = '{16'h8000, 2, 1'b0,  1, 15, 15};
    tbl[6] = '{16'h1248, 1, 1'b0,  4,  3, 12};

    repeat (2) step();
    check_quiet("reset");
    rst = 1'b0;
    step();
    check_quiet("post_reset");

    // Abort mid-scan after code 4 is accepted.
    bus.d_in = 16'h00F0;
    bus.load = 1'b1;
    step();
    bus.load  = 1'b0;
    bus.ready = 1'b1;
    check("abort_code4", bus.code, 4);
    step();
    bus.ready = 1'b0;
    check("abort_code5", bus.code, 5);
    rst = 1'b1;
    #1;
    check_quiet("async_reset");
    step();
    check_quiet("held_reset");
    rst = 1'b0;
    step();
    check_quiet("after_abort");
    run_vec(16'h0002, 0, 1'b0, cnt, first, fin);
    check("single_count", cnt, 1);
    check("single_code", first, 1);

    for (int t = 0; t < 7; t++) begin
      run_vec(tbl[t].vec, tbl[t].mode, tbl[t].inject, cnt, first, fin);
      check($sformatf("tbl%0d_count", t), cnt, tbl[t].exp_count);
      check($sformatf("tbl%0d_first", t), first, tbl[t].exp_first);
      check($sformatf("tbl%0d_final", t), fin, tbl[t].exp_final);
    end

    for (int t = 0; t < 40; t++) begin
      logic [15:0] v;
      v = (t % 2 == 0) ? 16'($urandom) : 16'($urandom & $urandom & $urandom);
      run_vec(v, 1 + (t % 2), (t % 5 == 0), cnt, first, fin);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/encoder_16x4_seq.md
# encoder_16x4_seq

Sequential 16-to-4 encoder: the inverse companion of `decoder_4x16`. It latches a 16-line request vector and emits the 4-bit index of every asserted line, lowest index first, one index per valid/ready handshake. Each emitted code drives `decoder_4x16` directly: bit order {w,a,b,c} matches that decoder's select inputs, so decoding all emitted codes reconstructs the vector.

## Interface
- CODE_W, 4, code width; line count N = 2**CODE_W (16).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  capture `d_in` and start a scan; honoured only when `busy`=0.
- d_in  in  N  request vector; bit i requests code i.
- busy  out  1  scan in progress; further loads ignored.
- valid  out  1  `code` holds a pending index.
- ready  in  1  consumer accepts `code` at this edge when `valid`=1.
- code  out  CODE_W  index of lowest pending line; code[3]=w, code[2]=a, code[1]=b, code[0]=c.
- last  out  1  with `valid`: this is the final pending index.
- done  out  1  one-cycle pulse: scan complete.

## Operation
- States: IDLE, SCAN, FIN.
- IDLE: busy=0, valid=0. `load`=1 at an edge latches `d_in` into the `pending` register and moves to SCAN.
- SCAN: busy=1. valid=1 iff pending≠0. code = index of lowest set bit of pending. last = 1 iff pending has exactly one bit set, i.e. (pending & (pending−1))==0 and pending≠0.
- Handshake: valid&&ready at an edge clears that bit of pending. If that bit was the last one, go to FIN.
- ready=0: pending, code, valid and last hold unchanged. No timeout.
- SCAN with pending==0 (zero vector loaded): valid stays 0. Go to FIN at the next edge.
- FIN: busy=1, valid=0, done=1. Next edge goes to IDLE.
- `load` while busy=1 (SCAN or FIN) is ignored, with no side effects.
- `code` is 0 whenever valid=0.
- All outputs decode from registered state and pending only. There is no combinational path from load, d_in or ready to any output.
- Reset (any time, including mid-scan): state IDLE, pending 0, busy 0, valid 0, code 0, last 0, done 0. No done pulse is emitted for an aborted scan.

## Timing
- Load accepted at edge E0: valid=1 and first code present in the cycle after E0 (latency 1).
- With ready held high, k set bits give k consecutive valid cycles. done is high in the cycle after the final handshake. busy=0 in the following cycle.
- Load-to-next-load minimum spacing: k+2 cycles. A zero vector takes 2 cycles: SCAN with valid=0, then FIN with done=1.
- Sustained throughput: one code per cycle.

## Structure
- Shared package `encoder_pkg`: CODE_W, N, state typedef {IDLE, SCAN, FIN}.
- Sub-module `prio_enc_16x4`: purely combinational. Inputs: 16-bit vector. Outputs: lowest-set-bit index, `any` flag, `one_hot` (single bit set) flag.
- Top: state register, pending register, bit-clear logic, output decode.

## Test plan
- Reset: assert rst mid-SCAN with d_in=16'h00F0 loaded, after code 4 accepted -> all outputs 0 immediately, no done. Then load 16'h0002 -> single code 1 with last=1, done next cycle.
- d_in=16'h8001, ready=1 -> code 0 (last=0), then code 15 (last=1). done in the following cycle; busy=0 one cycle after that.
- d_in=16'hFFFF, ready toggling 1/0 -> codes 0..15 ascending. code is stable while ready=0. Exactly 16 handshakes; last=1 only on code 15.
- d_in=16'h0000 -> valid never asserts. done=1 in the 2nd cycle after load; busy=0 in the 3rd.
- Load 16'h0A00 while busy on 16'h0030 -> only codes 4, 5 emitted. The ignored load leaves no trace.
- Round trip: random vectors, each emitted code fed through `decoder_4x16` -> OR of decoded one-hots equals the loaded vector. Codes are strictly ascending with no duplicates.
